// File: rtl/mem_responder.sv
// Memory-side responder for the multicycle CPU bus: one request at a time, programmable
// wait states, single- or paired-byte access to an internal byte array, valid/ready response.
module mem_responder #(
    parameter int DATA_W   = 8,
    parameter int ADDR_W   = 13,
    parameter int MEM_AW   = 8,
    parameter int WAIT_CYC = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_we,
    input  logic                req_pair,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [2*DATA_W-1:0] req_wdata,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [2*DATA_W-1:0] rsp_rdata,
    output logic                rsp_err
);

    localparam int CNT_W = (WAIT_CYC > 1) ? $clog2(WAIT_CYC) : 1;
    localparam logic [CNT_W-1:0] WAIT_LOAD = CNT_W'((WAIT_CYC > 0) ? (WAIT_CYC - 1) : 0);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WAIT    = 3'd1,
        ST_ACCESS  = 3'd2,
        ST_ACCESS2 = 3'd3,
        ST_RESP    = 3'd4
    } state_t;

    state_t                state_r;
    logic [CNT_W-1:0]      cnt_r;
    logic                  we_r;
    logic                  pair_r;
    logic [ADDR_W-1:0]     addr_r;
    logic [2*DATA_W-1:0]   wdata_r;

    logic [DATA_W-1:0]     mem [2**MEM_AW];

    logic [ADDR_W-1:0]     acc_addr_s;
    logic                  acc_ok_s;
    logic [DATA_W-1:0]     rd_byte_s;
    logic [DATA_W-1:0]     wr_byte_s;
    logic                  wr_en_s;

    // A byte is backed by storage only when every address bit above MEM_AW is clear.
    function automatic logic in_range(input logic [ADDR_W-1:0] a);
        return (a >> MEM_AW) == ADDR_W'(0);
    endfunction

    // Select the byte lane of the current access and decode read data / write enable.
    always_comb begin
        acc_addr_s = addr_r;
        wr_byte_s  = wdata_r[DATA_W-1:0];
        if (state_r == ST_ACCESS2) begin
            acc_addr_s = addr_r + ADDR_W'(1);
            wr_byte_s  = wdata_r[2*DATA_W-1:DATA_W];
        end else begin
            acc_addr_s = addr_r;
            wr_byte_s  = wdata_r[DATA_W-1:0];
        end
        acc_ok_s = in_range(acc_addr_s);
        if (acc_ok_s) begin
            rd_byte_s = mem[acc_addr_s[MEM_AW-1:0]];
        end else begin
            rd_byte_s = {DATA_W{1'b0}};
        end
        wr_en_s = we_r && acc_ok_s && ((state_r == ST_ACCESS) || (state_r == ST_ACCESS2));
    end

    // Storage array; deliberately not reset so contents survive a CPU reset.
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            mem[acc_addr_s[MEM_AW-1:0]] <= wr_byte_s;
        end
    end

    // Transaction FSM with registered handshake and response outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r   <= ST_IDLE;
            cnt_r     <= {CNT_W{1'b0}};
            we_r      <= 1'b0;
            pair_r    <= 1'b0;
            addr_r    <= {ADDR_W{1'b0}};
            wdata_r   <= {(2*DATA_W){1'b0}};
            req_ready <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_rdata <= {(2*DATA_W){1'b0}};
            rsp_err   <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (!req_ready) begin
                        req_ready <= 1'b1;
                    end else if (req_valid) begin
                        we_r      <= req_we;
                        pair_r    <= req_pair;
                        addr_r    <= req_addr;
                        wdata_r   <= req_wdata;
                        req_ready <= 1'b0;
                        rsp_err   <= 1'b0;
                        rsp_rdata <= {(2*DATA_W){1'b0}};
                        if (WAIT_CYC > 0) begin
                            state_r <= ST_WAIT;
                            cnt_r   <= WAIT_LOAD;
                        end else begin
                            state_r <= ST_ACCESS;
                        end
                    end
                end
                ST_WAIT: begin
                    if (cnt_r == {CNT_W{1'b0}}) begin
                        state_r <= ST_ACCESS;
                    end else begin
                        cnt_r <= cnt_r - CNT_W'(1);
                    end
                end
                ST_ACCESS: begin
                    if (!we_r) begin
                        rsp_rdata[DATA_W-1:0] <= rd_byte_s;
                    end
                    if (!acc_ok_s) begin
                        rsp_err <= 1'b1;
                    end
                    state_r <= pair_r ? ST_ACCESS2 : ST_RESP;
                end
                ST_ACCESS2: begin
                    if (!we_r) begin
                        rsp_rdata[2*DATA_W-1:DATA_W] <= rd_byte_s;
                    end
                    if (!acc_ok_s) begin
                        rsp_err <= 1'b1;
                    end
                    state_r <= ST_RESP;
                end
                ST_RESP: begin
                    // First RESP cycle raises valid; a handshake needs valid already high.
                    if (!rsp_valid) begin
                        rsp_valid <= 1'b1;
                    end else if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        req_ready <= 1'b1;
                        state_r   <= ST_IDLE;
                    end
                end
                default: begin
                    state_r   <= ST_IDLE;
                    req_ready <= 1'b0;
                    rsp_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder: a byte-array model predicts each response, which is
// queued at request time and popped when the DUT answers. A second instance uses WAIT_CYC=0.
module tb_mem_responder;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        req_valid, req_ready, req_we, req_pair;
    logic [12:0] req_addr;
    logic [15:0] req_wdata;
    logic        rsp_valid, rsp_ready, rsp_err;
    logic [15:0] rsp_rdata;

    logic        z_req_valid, z_req_ready, z_req_we, z_req_pair;
    logic [12:0] z_req_addr;
    logic [15:0] z_req_wdata;
    logic        z_rsp_valid, z_rsp_ready, z_rsp_err;
    logic [15:0] z_rsp_rdata;

    mem_responder #(.DATA_W(8), .ADDR_W(13), .MEM_AW(8), .WAIT_CYC(1)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_pair(req_pair),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
    );

    mem_responder #(.DATA_W(8), .ADDR_W(13), .MEM_AW(8), .WAIT_CYC(0)) dut0 (
        .clk(clk), .rst(rst),
        .req_valid(z_req_valid), .req_ready(z_req_ready), .req_we(z_req_we), .req_pair(z_req_pair),
        .req_addr(z_req_addr), .req_wdata(z_req_wdata),
        .rsp_valid(z_rsp_valid), .rsp_ready(z_rsp_ready), .rsp_rdata(z_rsp_rdata), .rsp_err(z_rsp_err)
    );

    typedef struct {
        logic [15:0] rdata;
        logic        err;
        int          lat;
    } exp_t;

    exp_t        sb[$];
    logic [7:0]  mdl [256];
    int          n_checks = 0;
    int          n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] mdl_rd(input logic [12:0] a);
        return (a[12:8] == 5'd0) ? mdl[a[7:0]] : 8'h00;
    endfunction

    // Full transaction on the WAIT_CYC=1 instance; hold>0 keeps rsp_ready low that many cycles.
    task automatic do_txn(input logic we, input logic pair, input logic [12:0] addr,
                          input logic [15:0] wdata, input int hold);
        exp_t        e;
        logic [12:0] a2;
        int          lat;
        bit          ok;
        a2    = addr + 13'd1;
        e.lat = pair ? 4 : 3;
        e.err = (addr[12:8] != 5'd0) || (pair && (a2[12:8] != 5'd0));
        if (we) begin
            e.rdata = 16'h0000;
            if (addr[12:8] == 5'd0) mdl[addr[7:0]] = wdata[7:0];
            if (pair && (a2[12:8] == 5'd0)) mdl[a2[7:0]] = wdata[15:8];
        end else begin
            e.rdata = {(pair ? mdl_rd(a2) : 8'h00), mdl_rd(addr)};
        end
        sb.push_back(e);

        @(negedge clk);
        req_we = we; req_pair = pair; req_addr = addr; req_wdata = wdata; req_valid = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (req_ready) begin ok = 1'b1; break; end
            @(negedge clk);
        end
        if (!ok) check("accept_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1 req_valid = 1'b0;

        ok = 1'b0; lat = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); lat++;
            #1;
            if (rsp_valid) begin ok = 1'b1; break; end
        end
        e = sb.pop_front();
        if (!ok) check("rsp_timeout", 32'd0, 32'd1);
        check("rdata", {16'h0, rsp_rdata}, {16'h0, e.rdata});
        check("err", {31'h0, rsp_err}, {31'h0, e.err});
        check("latency", lat, e.lat);
        check("req_ready_in_resp", {31'h0, req_ready}, 32'd0);

        if (hold > 0) begin
            @(negedge clk) req_valid = 1'b1;
            for (int i = 0; i < hold; i++) begin
                @(posedge clk); #1;
                check("hold_valid", {31'h0, rsp_valid}, 32'd1);
                check("hold_rdata", {16'h0, rsp_rdata}, {16'h0, e.rdata});
                check("hold_no_accept", {31'h0, req_ready}, 32'd0);
            end
        end
        @(negedge clk) rsp_ready = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        rsp_ready = 1'b0;
        check("valid_drop", {31'h0, rsp_valid}, 32'd0);
        check("ready_rise", {31'h0, req_ready}, 32'd1);
    endtask

    // Transaction on the zero-wait-state instance.
    task automatic z_txn(input logic we, input logic [12:0] addr, input logic [15:0] wdata,
                         input logic [15:0] exp_rdata, input logic exp_err);
        int lat;
        bit ok;
        @(negedge clk);
        z_req_we = we; z_req_pair = 1'b0; z_req_addr = addr; z_req_wdata = wdata; z_req_valid = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (z_req_ready) begin ok = 1'b1; break; end
            @(negedge clk);
        end
        if (!ok) check("z_accept_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1 z_req_valid = 1'b0;
        ok = 1'b0; lat = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); lat++;
            #1;
            if (z_rsp_valid) begin ok = 1'b1; break; end
        end
        if (!ok) check("z_rsp_timeout", 32'd0, 32'd1);
        check("z_latency", lat, 32'd2);
        check("z_rdata", {16'h0, z_rsp_rdata}, {16'h0, exp_rdata});
        check("z_err", {31'h0, z_rsp_err}, {31'h0, exp_err});
        @(negedge clk) z_rsp_ready = 1'b1;
        @(posedge clk); #1;
        z_rsp_ready = 1'b0;
        check("z_ready_rise", {31'h0, z_req_ready}, 32'd1);
    endtask

    initial begin
        rst = 1'b0;
        req_valid = 1'b0; req_we = 1'b0; req_pair = 1'b0; req_addr = 13'h0; req_wdata = 16'h0;
        rsp_ready = 1'b0;
        z_req_valid = 1'b0; z_req_we = 1'b0; z_req_pair = 1'b0; z_req_addr = 13'h0;
        z_req_wdata = 16'h0; z_rsp_ready = 1'b0;
        for (int i = 0; i < 256; i++) mdl[i] = 8'h00;

        repeat (3) @(posedge clk);
        #1;
        check("rst_req_ready", {31'h0, req_ready}, 32'd0);
        check("rst_rsp_valid", {31'h0, rsp_valid}, 32'd0);
        check("rst_rsp_rdata", {16'h0, rsp_rdata}, 32'd0);
        check("rst_rsp_err", {31'h0, rsp_err}, 32'd0);
        @(negedge clk) rst = 1'b1;
        @(posedge clk); #1;
        check("ready_after_rst", {31'h0, req_ready}, 32'd1);

        do_txn(1'b1, 1'b0, 13'h010, 16'h005A, 0);
        do_txn(1'b0, 1'b0, 13'h010, 16'h0000, 0);

        do_txn(1'b1, 1'b1, 13'h020, 16'hBEEF, 0);
        do_txn(1'b0, 1'b1, 13'h020, 16'h0000, 0);
        do_txn(1'b0, 1'b0, 13'h021, 16'h0000, 0);

        do_txn(1'b1, 1'b0, 13'h0FF, 16'h00C3, 0);
        do_txn(1'b1, 1'b0, 13'h000, 16'h003C, 0);
        do_txn(1'b0, 1'b0, 13'h1000, 16'h0000, 0);
        do_txn(1'b0, 1'b1, 13'h0FF, 16'h0000, 0);
        do_txn(1'b1, 1'b0, 13'h1010, 16'h0099, 0);
        do_txn(1'b0, 1'b0, 13'h010, 16'h0000, 0);
        do_txn(1'b0, 1'b1, 13'h1FFF, 16'h0000, 0);

        do_txn(1'b0, 1'b1, 13'h020, 16'h0000, 5);
        do_txn(1'b0, 1'b0, 13'h0FF, 16'h0000, 0);

        do_txn(1'b1, 1'b0, 13'h030, 16'h0011, 0);
        @(negedge clk);
        req_we = 1'b1; req_pair = 1'b0; req_addr = 13'h030; req_wdata = 16'h0077; req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        #1 rst = 1'b0;
        #1;
        check("abort_req_ready", {31'h0, req_ready}, 32'd0);
        check("abort_rsp_valid", {31'h0, rsp_valid}, 32'd0);
        check("abort_rsp_rdata", {16'h0, rsp_rdata}, 32'd0);
        check("abort_rsp_err", {31'h0, rsp_err}, 32'd0);
        repeat (3) @(posedge clk);
        #1;
        check("abort_held_valid", {31'h0, rsp_valid}, 32'd0);
        @(negedge clk) rst = 1'b1;
        @(posedge clk); #1;
        check("ready_after_rst2", {31'h0, req_ready}, 32'd1);
        do_txn(1'b0, 1'b0, 13'h030, 16'h0000, 0);
        do_txn(1'b0, 1'b1, 13'h020, 16'h0000, 0);

        z_txn(1'b0, 13'h1000, 16'h0000, 16'h0000, 1'b1);
        z_txn(1'b1, 13'h044, 16'h0042, 16'h0000, 1'b0);
        z_txn(1'b0, 13'h044, 16'h0000, 16'h0042, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
